adc_sample_packer: RTL

//  Downstream stage of the MCP3002 SPI leader. Accepts 10-bit conversion results tagged with

---
 rtl/adc_log_pkg.sv | 26 ++
 rtl/adc_sample_packer_sync_fifo.sv | 61 ++++++
 rtl/adc_sample_packer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/adc_log_pkg.sv
// Shared constants, FSM state encoding and frame-formatting helpers for the
// ADC sample packer.
package adc_log_pkg;

  localparam int         SAMPLE_W   = 10;
  localparam int         ENTRY_W    = SAMPLE_W + 1;  // {ch, data}
  localparam logic       FRAME_SYNC = 1'b1;          // MSB of byte0 marks a frame start
  localparam logic [7:0] DROP_MAX   = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } pack_state_e;

  // First frame byte: sync bit, two zero bits, channel, data[9:6].
  function automatic logic [7:0] frame_byte0(input logic [ENTRY_W-1:0] entry);
    return {FRAME_SYNC, 2'b00, entry[SAMPLE_W], entry[SAMPLE_W-1:6]};
  endfunction

  // Second frame byte: MSB clear so it can never be mistaken for a frame start.
  function automatic logic [7:0] frame_byte1(input logic [ENTRY_W-1:0] entry);
    return {2'b00, entry[5:0]};
  endfunction

endpackage

// File: rtl/adc_sample_packer_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. A push into a full FIFO
// is accepted when a pop happens on the same edge (the slot is freed as it is
// refilled). Reads are asynchronous so the consumer can capture the head entry
// on the same edge that pops it.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             accept_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign pop_ok    = pop_i & ~empty_o;
  assign push_ok   = push_i & (~full_o | pop_ok);
  assign accept_o  = push_ok;
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally at DEPTH (a power of two); count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_packer.sv
// Buffers channel-tagged ADC results and serialises each into a two-byte
// self-synchronising frame on a valid/ready byte stream. Samples arriving
// while the FIFO is full (and nothing is popped) are dropped and counted.
module adc_sample_packer #(
  parameter int SAMPLE_W = 10,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic                CLK_50MHz,
  input  logic                RESET,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_ch,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic [7:0]          byte_data,
  output logic [AW:0]         fill_level,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  import adc_log_pkg::*;

  pack_state_e     state_q;
  logic [SAMPLE_W:0] hold_q;
  logic            byte_valid_q;
  logic [7:0]      byte_data_q;
  logic            overflow_q;
  logic [7:0]      drop_count_q;

  logic [SAMPLE_W:0] fifo_rd_data;
  logic            fifo_accept;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic            frame_done;
  logic            pop;
  logic            drop;

  // The frame in flight finishes when its second byte is taken; a new entry
  // is popped either from IDLE or right then, giving back-to-back frames.
  assign frame_done = (state_q == LO) & byte_ready;
  assign pop        = ~fifo_empty & ((state_q == IDLE) | frame_done);
  assign drop       = sample_valid & ~fifo_accept;

  sync_fifo #(
    .WIDTH (SAMPLE_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i     (CLK_50MHz),
    .rst_i     (RESET),
    .push_i    (sample_valid),
    .wr_data_i ({sample_ch, sample_data}),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .accept_o  (fifo_accept),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Framing FSM: holds one popped entry and presents its two bytes in turn.
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_q       <= fifo_rd_data;
            byte_data_q  <= frame_byte0(fifo_rd_data);
            byte_valid_q <= 1'b1;
            state_q      <= HI;
          end
        end
        HI: begin
          if (byte_ready) begin
            byte_data_q <= frame_byte1(hold_q);
            state_q     <= LO;
          end
        end
        LO: begin
          if (byte_ready) begin
            if (pop) begin
              hold_q      <= fifo_rd_data;
              byte_data_q <= frame_byte0(fifo_rd_data);
              state_q     <= HI;
            end else begin
              byte_valid_q <= 1'b0;
              state_q      <= IDLE;
            end
          end
        end
        default: begin
          byte_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag and saturating count of samples lost to a full FIFO.
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != DROP_MAX) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign fill_level = fifo_count;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
